// File: rtl/audio_pkg.sv
// Shared types for the I2S DAC transmitter: state encoding and the stereo frame layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package audio_pkg;

   // Default bits per channel sample, two's complement
   localparam int SAMPLE_W_DEFAULT = 16;

   // Transmit FSM; explicit encodings keep state values stable in waveforms and netlists
   typedef enum logic [1:0] {
      WAIT_LEFT = 2'd0,
      LEFT      = 2'd1,
      RIGHT     = 2'd2
   } tx_state_t;

   // One stereo frame as it travels from the mixer; left sits in the upper half
   typedef struct packed {
      logic [SAMPLE_W_DEFAULT-1:0] left;
      logic [SAMPLE_W_DEFAULT-1:0] right;
   } frame_t;

endpackage

// File: rtl/audio_frame_fifo.sv
// Synchronous frame FIFO with registered occupancy; full/empty decode from the level register.
// Latency: a pushed entry is poppable the cycle after the push; read data is combinational from the head.
// Backpressure: pushes while full and pops while empty are dropped internally.
module audio_frame_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_dat,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_pop_dat,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             w_push;
   logic             w_pop;

   assign o_full    = (r_level == LW'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_pop_dat = r_mem[r_rd_ptr];
   assign w_push    = i_push & ~o_full;
   assign w_pop     = i_pop & ~o_empty;

   // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage array; contents need no reset because the pointers define what is valid
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
   end

endmodule

// File: rtl/audio_i2s_dac_tx.sv
// I2S DAC transmitter: buffers stereo frames and shifts them out MSB-first against codec BCLK/DACLRCK.
// Latency: audio_DACDAT changes at most 3 clk_clk cycles after a BCLK falling pin edge.
// Backpressure: s_ready is registered and drops while the frame FIFO is full.
module audio_i2s_dac_tx
   import audio_pkg::*;
#(
   parameter int SAMPLE_W   = SAMPLE_W_DEFAULT,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk_clk,
   input  logic                          reset_reset_n,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [SAMPLE_W-1:0]           s_left,
   input  logic [SAMPLE_W-1:0]           s_right,
   input  logic                          audio_BCLK,
   input  logic                          audio_DACLRCK,
   output logic                          audio_DACDAT,
   output logic                          underflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int CW = $clog2(SAMPLE_W + 1);
   localparam int FW = 2 * SAMPLE_W;

   // Synchroniser and edge-detect state
   logic                r_bclk_s1;
   logic                r_bclk_s2;
   logic                r_lrck_s1;
   logic                r_lrck_s2;
   logic                r_bclk_d;
   logic                r_lrck_prev;

   // Transmit state
   tx_state_t           r_state;
   logic [SAMPLE_W-1:0] r_shift;
   logic [SAMPLE_W-1:0] r_hold_right;
   logic [CW-1:0]       r_bit_cnt;
   logic                r_dacdat;
   logic                r_underflow;
   logic                r_s_ready;

   // Combinational decode
   logic                w_bfall;
   logic                w_lrck_chg;
   logic                w_left_start;
   logic                w_right_load;
   logic                w_push;
   logic                w_pop;
   logic [FW-1:0]       w_fifo_rd_dat;
   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic [LW-1:0]       w_fifo_level;
   logic [LW-1:0]       w_level_nxt;

   assign w_bfall      = r_bclk_d & ~r_bclk_s2;
   assign w_lrck_chg   = w_bfall & (r_lrck_s2 != r_lrck_prev);
   // A falling LRCK starts a left word from idle or after a right word
   assign w_left_start = w_lrck_chg & ~r_lrck_s2 & ((r_state == WAIT_LEFT) | (r_state == RIGHT));
   assign w_right_load = w_lrck_chg &  r_lrck_s2 &  (r_state == LEFT);
   // An empty FIFO at left start means underflow; a same-cycle push is not bypassed
   assign w_pop        = w_left_start & ~w_fifo_empty;
   assign w_push       = s_valid & r_s_ready & ~w_fifo_full;

   assign s_ready      = r_s_ready;
   assign audio_DACDAT = r_dacdat;
   assign underflow    = r_underflow;
   assign fifo_level   = w_fifo_level;

   audio_frame_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk      (clk_clk),
      .i_rst_n    (reset_reset_n),
      .i_push     (w_push),
      .i_push_dat ({s_left, s_right}),
      .i_pop      (w_pop),
      .o_pop_dat  (w_fifo_rd_dat),
      .o_full     (w_fifo_full),
      .o_empty    (w_fifo_empty),
      .o_level    (w_fifo_level)
   );

   // Identical 2-flop chains keep BCLK/LRCK alignment; LRCK history only advances on BCLK falls
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_bclk_s1   <= 1'b0;
         r_bclk_s2   <= 1'b0;
         r_lrck_s1   <= 1'b0;
         r_lrck_s2   <= 1'b0;
         r_bclk_d    <= 1'b0;
         r_lrck_prev <= 1'b0;
      end else begin
         r_bclk_s1 <= audio_BCLK;
         r_bclk_s2 <= r_bclk_s1;
         r_lrck_s1 <= audio_DACLRCK;
         r_lrck_s2 <= r_lrck_s1;
         r_bclk_d  <= r_bclk_s2;
         if (w_bfall) r_lrck_prev <= r_lrck_s2;
      end
   end

   // Channel FSM; idle ignores a rising LRCK so output always begins with a complete left word
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_state <= WAIT_LEFT;
      end else if (w_left_start) begin
         r_state <= LEFT;
      end else if (w_right_load) begin
         r_state <= RIGHT;
      end
   end

   // Hold register keeps the popped right sample until LRCK rises
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_hold_right <= '0;
      end else if (w_left_start) begin
         r_hold_right <= w_fifo_empty ? '0 : w_fifo_rd_dat[SAMPLE_W-1:0];
      end
   end

   // Shifter: the load fall is the I2S delay slot, then SAMPLE_W bits MSB-first, then zeros
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_dacdat  <= 1'b0;
      end else if (w_bfall) begin
         if (w_left_start) begin
            r_shift   <= w_fifo_empty ? '0 : w_fifo_rd_dat[FW-1:SAMPLE_W];
            r_bit_cnt <= CW'(SAMPLE_W);
         end else if (w_right_load) begin
            r_shift   <= r_hold_right;
            r_bit_cnt <= CW'(SAMPLE_W);
         end else if (r_bit_cnt != '0) begin
            r_dacdat  <= r_shift[SAMPLE_W-1];
            r_shift   <= {r_shift[SAMPLE_W-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt - CW'(1);
         end else begin
            r_dacdat  <= 1'b0;
         end
      end
   end

   // Underflow is a single-cycle flag raised by a left start that found the FIFO empty
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_underflow <= 1'b0;
      end else begin
         r_underflow <= w_left_start & w_fifo_empty;
      end
   end

   // Occupancy after this cycle's push/pop, used to register s_ready one cycle ahead
   always_comb begin
      w_level_nxt = w_fifo_level;
      if (w_push & ~w_pop) begin
         w_level_nxt = w_fifo_level + LW'(1);
      end else if (~w_push & w_pop) begin
         w_level_nxt = w_fifo_level - LW'(1);
      end
   end

   // Registered ready: low throughout reset, high the first cycle after release
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_s_ready <= 1'b0;
      end else begin
         r_s_ready <= (w_level_nxt != LW'(FIFO_DEPTH));
      end
   end

endmodule

// File: tb/tb_audio_i2s_dac_tx.sv
// Directed bench for audio_i2s_dac_tx with an I2S codec model (BCLK = clk/16, 24 BCLKs per half-frame).
// Latency: decoded bits are sampled on each BCLK rise, well after the DAC data register settles.
// Backpressure: frames wait in a bench queue and are offered with s_valid until s_ready accepts them.
module tb_audio_i2s_dac_tx;
   import audio_pkg::*;

   logic        clk_clk = 1'b0;
   logic        reset_reset_n;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] s_left;
   logic [15:0] s_right;
   logic        audio_BCLK;
   logic        audio_DACLRCK;
   logic        audio_DACDAT;
   logic        underflow;
   logic [2:0]  fifo_level;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          uf_rises;
   int          uf_high;
   logic        uf_prev;
   frame_t      pq[$];

   audio_i2s_dac_tx dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_left        (s_left),
      .s_right       (s_right),
      .audio_BCLK    (audio_BCLK),
      .audio_DACLRCK (audio_DACLRCK),
      .audio_DACDAT  (audio_DACDAT),
      .underflow     (underflow),
      .fifo_level    (fifo_level)
   );

   always #10 clk_clk = ~clk_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic frame_t mkf(input logic [15:0] l, input logic [15:0] r);
      return frame_t'({l, r});
   endfunction

   // Expected 24-bit half-frame as seen on BCLK rises: delay slot, 16 data bits, 7 zeros
   function automatic logic [23:0] hx(input logic [15:0] w);
      return {1'b0, w, 7'b0};
   endfunction

   // One clock cycle: offer the queue head, advance, then sample underflow away from the edge
   task automatic tick();
      logic rdy;
      if (pq.size() > 0) begin
         s_valid = 1'b1;
         s_left  = pq[0].left;
         s_right = pq[0].right;
      end else begin
         s_valid = 1'b0;
      end
      rdy = s_ready;
      @(posedge clk_clk);
      if (s_valid && rdy) void'(pq.pop_front());
      #3;
      if (underflow) begin
         uf_high++;
         if (!uf_prev) uf_rises++;
      end
      uf_prev = underflow;
   endtask

   // One codec half-frame of 24 BCLKs; optional reset assert/release points and a push injected
   // on the exact cycle the DUT acts on the LRCK edge (third clock after the BCLK fall)
   task automatic half_frame(input logic lr, input logic [23:0] exp, input string tag,
                             input int assert_k, input int release_k,
                             input logic inject, input frame_t inj_f);
      logic [23:0] bits;
      bits = '0;
      for (int k = 0; k < 24; k++) begin
         if (k == release_k) reset_reset_n = 1'b1;
         audio_BCLK = 1'b0;
         if (k == 0) audio_DACLRCK = lr;
         for (int c = 0; c < 8; c++) begin
            if (inject && k == 0 && c == 2) pq.push_back(inj_f);
            tick();
            if (k == release_k && c == 0) chk({tag, " s_ready after release"}, 32'(s_ready), 32'd1);
         end
         audio_BCLK = 1'b1;
         bits[23-k] = audio_DACDAT;
         if (k == assert_k) reset_reset_n = 1'b0;
         for (int c = 0; c < 8; c++) begin
            tick();
            if (k == assert_k && c == 0) begin
               chk({tag, " dacdat in reset"}, 32'(audio_DACDAT), 32'd0);
               chk({tag, " level in reset"}, 32'(fifo_level), 32'd0);
               chk({tag, " s_ready in reset"}, 32'(s_ready), 32'd0);
            end
         end
      end
      chk(tag, 32'(bits), 32'(exp));
   endtask

   initial begin
      reset_reset_n = 1'b0;
      s_valid       = 1'b0;
      s_left        = '0;
      s_right       = '0;
      audio_BCLK    = 1'b1;
      audio_DACLRCK = 1'b1;
      uf_rises      = 0;
      uf_high       = 0;
      uf_prev       = 1'b0;
      @(posedge clk_clk);
      #3;
      repeat (3) tick();

      // Reset values
      chk("rst dacdat", 32'(audio_DACDAT), 32'd0);
      chk("rst underflow", 32'(underflow), 32'd0);
      chk("rst level", 32'(fifo_level), 32'd0);
      chk("rst s_ready", 32'(s_ready), 32'd0);

      // Release reset mid right half with a frame already waiting; output stays 0
      pq.push_back(mkf(16'hA5C3, 16'h0F0F));
      half_frame(1'b1, 24'h0, "release mid right", -1, 10, 1'b0, mkf(16'h0, 16'h0));
      chk("level after first push", 32'(fifo_level), 32'd1);

      // Basic frame
      uf_rises = 0; uf_high = 0;
      half_frame(1'b0, hx(16'hA5C3), "basic L", -1, -1, 1'b0, mkf(16'h0, 16'h0));
      half_frame(1'b1, hx(16'h0F0F), "basic R", -1, -1, 1'b0, mkf(16'h0, 16'h0));
      chk("basic no underflow", 32'(uf_rises), 32'd0);

      // Idle frames: one single-cycle underflow per frame, zero data
      uf_rises = 0; uf_high = 0;
      for (int f = 0; f < 3; f++) begin
         half_frame(1'b0, 24'h0, "idle L", -1, -1, 1'b0, mkf(16'h0, 16'h0));
         half_frame(1'b1, 24'h0, "idle R", -1, -1, 1'b0, mkf(16'h0, 16'h0));
      end
      chk("idle underflow pulses", 32'(uf_rises), 32'd3);
      chk("idle underflow cycles", 32'(uf_high), 32'd3);

      // Back-pressure with LRCK stopped: 4 accepted, 2 waiting
      for (int i = 1; i <= 6; i++) pq.push_back(mkf(16'h1111 * 16'(i), 16'hE000 + 16'(i)));
      repeat (12) tick();
      chk("bp level full", 32'(fifo_level), 32'd4);
      chk("bp s_ready low", 32'(s_ready), 32'd0);
      chk("bp waiting", 32'(pq.size()), 32'd2);
      uf_rises = 0; uf_high = 0;
      for (int i = 1; i <= 6; i++) begin
         half_frame(1'b0, hx(16'h1111 * 16'(i)), "bp L", -1, -1, 1'b0, mkf(16'h0, 16'h0));
         half_frame(1'b1, hx(16'hE000 + 16'(i)), "bp R", -1, -1, 1'b0, mkf(16'h0, 16'h0));
      end
      chk("bp no underflow", 32'(uf_rises), 32'd0);
      chk("bp drained level", 32'(fifo_level), 32'd0);
      chk("bp drained queue", 32'(pq.size()), 32'd0);

      // Push on the exact left-start cycle with an empty FIFO
      uf_rises = 0; uf_high = 0;
      half_frame(1'b0, 24'h0, "race L", -1, -1, 1'b1, mkf(16'h1357, 16'h2468));
      half_frame(1'b1, 24'h0, "race R", -1, -1, 1'b0, mkf(16'h0, 16'h0));
      chk("race underflow pulses", 32'(uf_rises), 32'd1);
      chk("race underflow cycles", 32'(uf_high), 32'd1);
      chk("race level kept", 32'(fifo_level), 32'd1);
      uf_rises = 0; uf_high = 0;
      half_frame(1'b0, hx(16'h1357), "race next L", -1, -1, 1'b0, mkf(16'h0, 16'h0));
      half_frame(1'b1, hx(16'h2468), "race next R", -1, -1, 1'b0, mkf(16'h0, 16'h0));
      chk("race next no underflow", 32'(uf_rises), 32'd0);

      // Reset during bit 7 of a left word; queued frame discarded
      pq.push_back(mkf(16'hFFFF, 16'h1234));
      pq.push_back(mkf(16'hABCD, 16'hEF01));
      repeat (4) tick();
      chk("pre-reset level", 32'(fifo_level), 32'd2);
      half_frame(1'b0, 24'h7F0000, "reset mid L", 7, 8, 1'b0, mkf(16'h0, 16'h0));
      half_frame(1'b1, 24'h0, "post reset R", -1, -1, 1'b0, mkf(16'h0, 16'h0));
      chk("post reset level", 32'(fifo_level), 32'd0);
      pq.push_back(mkf(16'hC001, 16'h8005));
      uf_rises = 0; uf_high = 0;
      half_frame(1'b0, hx(16'hC001), "resume L", -1, -1, 1'b0, mkf(16'h0, 16'h0));
      half_frame(1'b1, hx(16'h8005), "resume R", -1, -1, 1'b0, mkf(16'h0, 16'h0));
      chk("resume no underflow", 32'(uf_rises), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
